dmem_mmio_responder: RTL and testbench

//   Responder end of the processor data-memory bus (address/data/wren -> q).

---
 rtl/dmem_mmio_responder.sv | 134 +++++++++++++
 tb/tb_dmem_mmio_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// Data-memory bus responder: word RAM plus an MMIO window holding a cycle counter,
// a byte TX FIFO drained over valid/ready, a status word and an LED register.
module dmem_mmio_responder #(
  parameter int                ADDR_W     = 12,
  parameter int                RAM_WORDS  = 1024,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 12'hFF0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data,
  input  logic              wren,
  output logic [31:0]       q,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [31:0]       led
);

  localparam int                RAM_AW    = $clog2(RAM_WORDS);
  localparam int                PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W:0]   RAM_LIMIT = (ADDR_W + 1)'(RAM_WORDS);
  localparam logic [3:0]        DEPTH_CNT = 4'(FIFO_DEPTH);

  localparam logic [3:0] OFF_CNT  = 4'd0;
  localparam logic [3:0] OFF_TXD  = 4'd1;
  localparam logic [3:0] OFF_STAT = 4'd2;
  localparam logic [3:0] OFF_LED  = 4'd3;

  logic [31:0] ramMem  [RAM_WORDS];
  logic [7:0]  fifoMem [FIFO_DEPTH];

  logic [31:0]      q_q, q_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      led_q, led_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_q, ovf_d;

  logic              isRam, isMmio;
  logic [3:0]        offset;
  logic [RAM_AW-1:0] ramIdx;
  logic              fifoEmpty, fifoFull;
  logic              popEn, pushReq, pushEn;
  logic [31:0]       statWord;

  // The window is 16-word aligned, so the upper address bits select it.
  assign isRam     = ({1'b0, address} < RAM_LIMIT);
  assign isMmio    = (address[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
  assign offset    = address[3:0] - MMIO_BASE[3:0];
  assign ramIdx    = address[RAM_AW-1:0];
  assign fifoEmpty = (count_q == 4'd0);
  assign fifoFull  = (count_q == DEPTH_CNT);
  assign popEn     = !fifoEmpty && tx_ready;
  assign pushReq   = wren && !isRam && isMmio && (offset == OFF_TXD);
  assign pushEn    = pushReq && (!fifoFull || popEn);
  assign statWord  = {20'b0, count_q, 5'b0, ovf_q, fifoFull, fifoEmpty};

  always_comb begin
    q_d     = 32'h0;
    cnt_d   = cnt_q + 32'd1;
    led_d   = led_q;
    ovf_d   = ovf_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;

    // Reads always see the pre-edge state, including RAM on a same-cycle write.
    if (isRam) begin
      q_d = ramMem[ramIdx];
    end else if (isMmio) begin
      case (offset)
        OFF_CNT:  q_d = cnt_q;
        OFF_STAT: q_d = statWord;
        OFF_LED:  q_d = led_q;
        default:  q_d = 32'h0;
      endcase
    end

    if (wren && !isRam && isMmio) begin
      case (offset)
        OFF_CNT:  cnt_d = data;
        OFF_STAT: if (data[2]) ovf_d = 1'b0;
        OFF_LED:  led_d = data;
        default:  ;
      endcase
    end

    if (pushReq && !pushEn) ovf_d = 1'b1;

    if (pushEn) wrPtr_d = wrPtr_q + 1'b1;
    if (popEn)  rdPtr_d = rdPtr_q + 1'b1;

    case ({pushEn, popEn})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q     <= 32'h0;
      cnt_q   <= 32'h0;
      led_q   <= 32'h0;
      ovf_q   <= 1'b0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= 4'd0;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      ovf_q   <= ovf_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage arrays are not reset; only the pointers and count define FIFO contents.
  always_ff @(posedge clock) begin
    if (wren && isRam) ramMem[ramIdx] <= data;
    if (pushEn) fifoMem[wrPtr_q] <= data[7:0];
  end

  assign q        = q_q;
  assign led      = led_q;
  assign tx_valid = !fifoEmpty;
  assign tx_data  = fifoEmpty ? 8'h00 : fifoMem[rdPtr_q];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: a queue/array reference model checked every
// cycle, plus literal expectations taken from hand-worked bus scenarios.
module tb_dmem_mmio_responder;

  localparam logic [11:0] GAP_A  = 12'h500;
  localparam logic [11:0] CNT_A  = 12'hFF0;
  localparam logic [11:0] TXD_A  = 12'hFF1;
  localparam logic [11:0] STAT_A = 12'hFF2;
  localparam logic [11:0] LED_A  = 12'hFF3;

  logic        clock;
  logic        reset;
  logic [11:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] led;

  int checks;
  int errors;
  bit checkEn;
  bit rstVal;

  logic [31:0] ramM [int];
  logic [7:0]  fifoM [$];
  logic [31:0] cntM, ledM, expQ;
  bit          ovfM;

  dmem_mmio_responder dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .q        (q),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .led      (led)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    expQ = 32'h0;
    cntM = 32'h0;
    ledM = 32'h0;
    ovfM = 1'b0;
    fifoM.delete();
  endtask

  // Reference behaviour at one rising edge, from the bus rules directly.
  task automatic modelStep();
    logic [31:0] rd;
    logic [31:0] nextCnt;
    bit          popNow;
    bit          pushNow;
    int          sz;
    if (!reset) begin
      modelReset();
      return;
    end
    sz      = fifoM.size();
    popNow  = (sz > 0) && tx_ready;
    pushNow = 1'b0;
    rd      = 32'h0;
    if (address < 12'd1024) begin
      rd = ramM.exists(int'(address)) ? ramM[int'(address)] : 32'h0;
    end else if (address == CNT_A) begin
      rd = cntM;
    end else if (address == STAT_A) begin
      rd = {20'b0, 4'(sz), 5'b0, ovfM, (sz == 8), (sz == 0)};
    end else if (address == LED_A) begin
      rd = ledM;
    end
    expQ    = rd;
    nextCnt = cntM + 32'd1;
    if (wren) begin
      if (address < 12'd1024) ramM[int'(address)] = data;
      else if (address == CNT_A) nextCnt = data;
      else if (address == TXD_A) begin
        if (sz < 8 || popNow) pushNow = 1'b1;
        else ovfM = 1'b1;
      end
      else if (address == STAT_A) begin
        if (data[2]) ovfM = 1'b0;
      end
      else if (address == LED_A) ledM = data;
    end
    if (popNow)  void'(fifoM.pop_front());
    if (pushNow) fifoM.push_back(data[7:0]);
    cntM = nextCnt;
  endtask

  task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
    @(negedge clock);
    #1;
    reset    = rstVal;
    address  = a;
    data     = d;
    wren     = w;
    tx_ready = r;
    @(posedge clock);
    modelStep();
    #1;
  endtask

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("q", q, expQ);
      checkOutput("tx_valid", {31'b0, tx_valid}, {31'b0, fifoM.size() != 0});
      checkOutput("tx_data", {24'b0, tx_data}, {24'b0, (fifoM.size() != 0) ? fifoM[0] : 8'h00});
      checkOutput("led", led, ledM);
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    checkEn  = 1'b0;
    rstVal   = 1'b0;
    reset    = 1'b1;
    address  = GAP_A;
    data     = 32'h0;
    wren     = 1'b0;
    tx_ready = 1'b0;
    #2;
    reset = 1'b0;
    modelReset();
    checkEn = 1'b1;
    applyStimulus(GAP_A, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_q", q, 32'h0);
    checkOutput("rst_valid", {31'b0, tx_valid}, 32'h0);
    checkOutput("rst_txdata", {24'b0, tx_data}, 32'h0);
    checkOutput("rst_led", led, 32'h0);
    rstVal = 1'b1;

    // RAM write/read and read-before-write
    applyStimulus(12'd0,    32'hA5A5A5A5, 1'b1, 1'b0);
    applyStimulus(12'd1023, 32'h5A5A5A5A, 1'b1, 1'b0);
    applyStimulus(12'd5,    32'hDEADBEEF, 1'b1, 1'b0);
    applyStimulus(12'd5,    32'h0, 1'b0, 1'b0);
    checkOutput("ram_rd5", q, 32'hDEADBEEF);
    applyStimulus(12'd5,    32'h1, 1'b1, 1'b0);
    checkOutput("ram_rbw5", q, 32'hDEADBEEF);
    applyStimulus(12'd5,    32'h0, 1'b0, 1'b0);
    checkOutput("ram_new5", q, 32'h1);

    // Gap and unmapped MMIO writes are ignored and read as zero
    applyStimulus(12'h400, 32'h1234, 1'b1, 1'b0);
    applyStimulus(12'hFF7, 32'h1234, 1'b1, 1'b0);
    applyStimulus(12'h400, 32'h0, 1'b0, 1'b0);
    checkOutput("gap_rd", q, 32'h0);
    applyStimulus(12'hFF7, 32'h0, 1'b0, 1'b0);
    checkOutput("mmio7_rd", q, 32'h0);
    applyStimulus(12'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("ram_rd0", q, 32'hA5A5A5A5);
    applyStimulus(12'd1023, 32'h0, 1'b0, 1'b0);
    checkOutput("ram_rd1023", q, 32'h5A5A5A5A);

    // LED register
    applyStimulus(LED_A, 32'hCAFE0001, 1'b1, 1'b0);
    checkOutput("led_wr", led, 32'hCAFE0001);
    applyStimulus(LED_A, 32'h0, 1'b0, 1'b0);
    checkOutput("led_rd", q, 32'hCAFE0001);

    // Counter load and wrap
    applyStimulus(CNT_A, 32'hFFFFFFFE, 1'b1, 1'b0);
    applyStimulus(GAP_A, 32'h0, 1'b0, 1'b0);
    applyStimulus(CNT_A, 32'h0, 1'b0, 1'b0);
    checkOutput("cnt_max", q, 32'hFFFFFFFF);
    applyStimulus(CNT_A, 32'h0, 1'b0, 1'b0);
    checkOutput("cnt_wrap", q, 32'h0);

    // Fill the FIFO with the consumer stalled, then overflow it
    for (int i = 0; i < 8; i++) applyStimulus(TXD_A, 32'h41 + i, 1'b1, 1'b0);
    applyStimulus(STAT_A, 32'h0, 1'b0, 1'b0);
    checkOutput("stat_full", q, 32'h802);
    applyStimulus(TXD_A, 32'h49, 1'b1, 1'b0);
    applyStimulus(STAT_A, 32'h0, 1'b0, 1'b0);
    checkOutput("stat_ovf", q, 32'h806);
    checkOutput("txdata_held", {24'b0, tx_data}, 32'h41);

    // Drain in order, one byte per cycle
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_valid", {31'b0, tx_valid}, 32'h1);
      checkOutput("drain_byte", {24'b0, tx_data}, 32'h41 + i);
      applyStimulus(GAP_A, 32'h0, 1'b0, 1'b1);
    end
    checkOutput("drained_valid", {31'b0, tx_valid}, 32'h0);
    applyStimulus(STAT_A, 32'h0, 1'b0, 1'b0);
    checkOutput("stat_empty_ovf", q, 32'h005);
    applyStimulus(STAT_A, 32'h4, 1'b1, 1'b0);
    applyStimulus(STAT_A, 32'h0, 1'b0, 1'b0);
    checkOutput("stat_cleared", q, 32'h001);

    // Push and pop on a full FIFO in the same cycle
    for (int i = 0; i < 8; i++) applyStimulus(TXD_A, 32'h50 + i, 1'b1, 1'b0);
    applyStimulus(TXD_A, 32'h58, 1'b1, 1'b1);
    applyStimulus(STAT_A, 32'h0, 1'b0, 1'b0);
    checkOutput("stat_pushpop", q, 32'h802);
    checkOutput("head_after_pop", {24'b0, tx_data}, 32'h51);

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++) applyStimulus(GAP_A, 32'h0, 1'b0, 1'b1);
    checkOutput("middrain_head", {24'b0, tx_data}, 32'h54);
    @(negedge clock);
    #1;
    rstVal = 1'b0;
    reset  = 1'b0;
    modelReset();
    #1;
    checkOutput("async_valid", {31'b0, tx_valid}, 32'h0);
    checkOutput("async_txdata", {24'b0, tx_data}, 32'h0);
    checkOutput("async_led", led, 32'h0);
    checkOutput("async_q", q, 32'h0);
    applyStimulus(GAP_A, 32'h0, 1'b0, 1'b0);
    rstVal = 1'b1;
    applyStimulus(CNT_A, 32'h0, 1'b0, 1'b0);
    checkOutput("cnt_after_rst", q, 32'h0);
    applyStimulus(STAT_A, 32'h0, 1'b0, 1'b0);
    checkOutput("stat_after_rst", q, 32'h001);
    applyStimulus(CNT_A, 32'h0, 1'b0, 1'b0);
    checkOutput("cnt_counting", q, 32'h2);
    applyStimulus(GAP_A, 32'h0, 1'b0, 1'b0);

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
